// File: rtl/hp_pkg.sv
// hp_pkg: opcodes, flag bit indices and the sequencer FSM encoding
// shared by hp_ctrl, its bus interface and the half-precision datapath.
package hp_pkg;

    // Opcode is {op[1:0], sr}; the LSB selects stochastic rounding.
    localparam logic [2:0] ADD_RN = 3'b000;
    localparam logic [2:0] ADD_SR = 3'b001;
    localparam logic [2:0] SUB_RN = 3'b010;
    localparam logic [2:0] SUB_SR = 3'b011;
    localparam logic [2:0] MUL_RN = 3'b100;
    localparam logic [2:0] MUL_SR = 3'b101;
    localparam logic [2:0] DIV_RN = 3'b110;
    localparam logic [2:0] DIV_SR = 3'b111;

    // Bit positions within the 6-bit class flag vector.
    localparam int ZERO = 5;
    localparam int INF  = 4;
    localparam int SUBN = 3;
    localparam int NORM = 2;
    localparam int QNAN = 1;
    localparam int SNAN = 0;

    localparam int NUM_FLAGS = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } hp_ctrl_state_t;

endpackage

// File: rtl/hp_ctrl_if.sv
// hp_ctrl_if: request, datapath and response bundle of hp_ctrl.
// master = core/datapath side, slave = hp_ctrl.
interface hp_ctrl_if #(
    parameter int num_bits = 16
);
    logic                req_valid;
    logic                req_ready;
    logic [num_bits-1:0] req_a;
    logic [num_bits-1:0] req_b;
    logic [2:0]          req_op;

    logic [num_bits-1:0] dp_a;
    logic [num_bits-1:0] dp_b;
    logic [2:0]          dp_op;
    logic                dp_ops_ready;
    logic [num_bits-1:0] dp_res;
    logic [5:0]          dp_flags;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [num_bits-1:0] rsp_res;
    logic [5:0]          rsp_flags;

    logic [5:0]          sticky_flags;
    logic                sticky_clr;
    logic                busy;

    modport master (
        output req_valid, req_a, req_b, req_op,
        output dp_res, dp_flags,
        output rsp_ready, sticky_clr,
        input  req_ready, dp_a, dp_b, dp_op, dp_ops_ready,
        input  rsp_valid, rsp_res, rsp_flags,
        input  sticky_flags, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        input  dp_res, dp_flags,
        input  rsp_ready, sticky_clr,
        output req_ready, dp_a, dp_b, dp_op, dp_ops_ready,
        output rsp_valid, rsp_res, rsp_flags,
        output sticky_flags, busy
    );

endinterface

// File: rtl/hp_ctrl.sv
// hp_ctrl: one-at-a-time request/response sequencer for the hp datapath.
// Ports: clk, reset (async, active-high), bus (hp_ctrl_if.slave).
module hp_ctrl
    import hp_pkg::*;
#(
    parameter int num_bits   = 16,
    parameter int lat_cycles = 2
) (
    input  logic     clk,
    input  logic     reset,
    hp_ctrl_if.slave bus
);

    localparam int            CW       = $clog2(lat_cycles + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(lat_cycles);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    hp_ctrl_state_t state;
    logic [CW-1:0]  cnt;

    logic [num_bits-1:0] dp_a;
    logic [num_bits-1:0] dp_b;
    logic [2:0]          dp_op;
    logic [num_bits-1:0] rsp_res;
    logic [5:0]          rsp_flags;
    logic [5:0]          sticky;

    logic capture;
    logic [5:0] sticky_base;

    assign capture = (state == EXEC) && (cnt == CNT_LAST);

    // A clear coinciding with a capture keeps the freshly captured bits.
    assign sticky_base = bus.sticky_clr ? '0 : sticky;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_op     <= '0;
            rsp_res   <= '0;
            rsp_flags <= '0;
            sticky    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        dp_a  <= bus.req_a;
                        dp_b  <= bus.req_b;
                        dp_op <= bus.req_op;
                        cnt   <= CNT_LOAD;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt - CNT_LAST;
                    if (capture) begin
                        rsp_res   <= bus.dp_res;
                        rsp_flags <= bus.dp_flags;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            sticky <= sticky_base | (capture ? bus.dp_flags : 6'b0);
        end
    end

    // Start pulse: the counter still holds its load value only in the
    // first EXEC cycle.
    assign bus.dp_ops_ready = (state == EXEC) && (cnt == CNT_LOAD);

    assign bus.req_ready    = (state == IDLE) && !reset;
    assign bus.rsp_valid    = (state == RESP);
    assign bus.busy         = (state != IDLE);
    assign bus.dp_a         = dp_a;
    assign bus.dp_b         = dp_b;
    assign bus.dp_op        = dp_op;
    assign bus.rsp_res      = rsp_res;
    assign bus.rsp_flags    = rsp_flags;
    assign bus.sticky_flags = sticky;

endmodule

// File: tb/tb_hp_ctrl.sv
// tb_hp_ctrl: scenario tasks against two hp_ctrl instances
// (lat_cycles 2 and 1) fed by a stand-in datapath.
module tb_hp_ctrl;
    import hp_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hp_ctrl_if #(.num_bits(16)) b0 ();
    hp_ctrl_if #(.num_bits(16)) b1 ();

    hp_ctrl #(.num_bits(16), .lat_cycles(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (b0.slave)
    );

    hp_ctrl #(.num_bits(16), .lat_cycles(1)) dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (b1.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [21:0] sb[$];

    localparam logic [21:0] JUNK = {16'hDEAD, 6'b111111};

    function automatic logic [5:0] classify(input logic [15:0] r);
        logic [4:0] e;
        logic [9:0] m;
        e = r[14:10];
        m = r[9:0];
        if (e == 5'd0 && m == 10'd0) return 6'b100000;
        if (e == 5'd0) return 6'b001000;
        if (e == 5'd31 && m == 10'd0) return 6'b010000;
        if (e == 5'd31 && m[9]) return 6'b000010;
        if (e == 5'd31) return 6'b000001;
        return 6'b000100;
    endfunction

    // Stand-in datapath: multiply by 1.0 is exact, other ops are placeholders.
    function automatic logic [21:0] dp_fn(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [2:0] op);
        logic [15:0] r;
        case (op[2:1])
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = (a == 16'h3C00) ? b : ((b == 16'h3C00) ? a : (a ^ b));
            default: r = a & b;
        endcase
        return {r, classify(r)};
    endfunction

    // Lat-2 datapath result is only valid from the second cycle after the
    // start pulse; before that it shows junk so early sampling is visible.
    int since0;
    always @(posedge clk or posedge reset) begin
        if (reset) since0 <= 0;
        else if (b0.dp_ops_ready) since0 <= 1;
        else if (since0 < 99) since0 <= since0 + 1;
    end

    logic [21:0] b0_out;
    logic [21:0] b1_out;
    assign b0_out = (b0.dp_ops_ready || since0 == 0) ? JUNK
                  : dp_fn(b0.dp_a, b0.dp_b, b0.dp_op);
    assign b0.dp_res   = b0_out[21:6];
    assign b0.dp_flags = b0_out[5:0];
    assign b1_out = dp_fn(b1.dp_a, b1.dp_b, b1.dp_op);
    assign b1.dp_res   = b1_out[21:6];
    assign b1.dp_flags = b1_out[5:0];

    // Called at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic drive_req(input logic [15:0] a, input logic [15:0] b,
                             input logic [2:0] op);
        b0.req_a = a;
        b0.req_b = b;
        b0.req_op = op;
        b0.req_valid = 1'b1;
        @(negedge clk);
        b0.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({b0.req_ready, b0.busy, b0.rsp_valid, b0.dp_ops_ready} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b want=0000",
                     {b0.req_ready, b0.busy, b0.rsp_valid, b0.dp_ops_ready});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (b0.req_ready !== 1'b1 || b1.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy got=%b%b want=11", b0.req_ready, b1.req_ready);
        end
        checks++;
        if ({b0.dp_a, b0.dp_b, b0.dp_op, b0.rsp_res, b0.rsp_flags, b0.sticky_flags,
             b0.busy} !== '0) begin
            errors++;
            $display("FAIL reset_regs dp_a=%h rsp_res=%h flags=%b sticky=%b want 0",
                     b0.dp_a, b0.rsp_res, b0.rsp_flags, b0.sticky_flags);
        end
    endtask

    task automatic test_basic_mul();
        logic [21:0] exp;
        sb.push_back({16'h4000, 6'b000100});
        drive_req(16'h3C00, 16'h4000, MUL_RN);
        checks++;
        if (b0.dp_ops_ready !== 1'b1 || b0.req_ready !== 1'b0 || b0.busy !== 1'b1) begin
            errors++;
            $display("FAIL mul_c1 ops_ready=%b req_ready=%b busy=%b want 1 0 1",
                     b0.dp_ops_ready, b0.req_ready, b0.busy);
        end
        @(negedge clk);
        checks++;
        if (b0.dp_ops_ready !== 1'b0 || b0.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_c2 ops_ready=%b rsp_valid=%b want 0 0",
                     b0.dp_ops_ready, b0.rsp_valid);
        end
        checks++;
        if (b0.dp_a !== 16'h3C00 || b0.dp_b !== 16'h4000 || b0.dp_op !== MUL_RN) begin
            errors++;
            $display("FAIL mul_hold a=%h b=%h op=%b want 3c00 4000 100",
                     b0.dp_a, b0.dp_b, b0.dp_op);
        end
        @(negedge clk);
        checks++;
        if (b0.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL mul_c3_valid got=%b want=1", b0.rsp_valid);
        end
        exp = sb.pop_front();
        checks++;
        if (b0.rsp_res !== exp[21:6] || b0.rsp_flags !== exp[5:0]) begin
            errors++;
            $display("FAIL mul_rsp got=%h/%b want=%h/%b",
                     b0.rsp_res, b0.rsp_flags, exp[21:6], exp[5:0]);
        end
        @(negedge clk);
        checks++;
        if (b0.req_ready !== 1'b1 || b0.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_c4 req_ready=%b rsp_valid=%b want 1 0",
                     b0.req_ready, b0.rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [21:0] exp;
        b0.rsp_ready = 1'b0;
        sb.push_back(dp_fn(16'h3C00, 16'h3C00, ADD_RN));
        drive_req(16'h3C00, 16'h3C00, ADD_RN);
        @(negedge clk);
        @(negedge clk);
        exp = sb.pop_front();
        b0.req_a = 16'h1234;
        b0.req_b = 16'h5678;
        b0.req_op = DIV_RN;
        b0.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (b0.rsp_valid !== 1'b1 || b0.rsp_res !== exp[21:6] ||
                b0.rsp_flags !== exp[5:0]) begin
                errors++;
                $display("FAIL bp_hold[%0d] valid=%b res=%h flags=%b want 1 %h %b",
                         i, b0.rsp_valid, b0.rsp_res, b0.rsp_flags, exp[21:6], exp[5:0]);
            end
            checks++;
            if (b0.req_ready !== 1'b0 || b0.dp_ops_ready !== 1'b0 ||
                b0.dp_a !== 16'h3C00) begin
                errors++;
                $display("FAIL bp_noacc[%0d] req_ready=%b ops_ready=%b dp_a=%h want 0 0 3c00",
                         i, b0.req_ready, b0.dp_ops_ready, b0.dp_a);
            end
            @(negedge clk);
        end
        b0.req_valid = 1'b0;
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (b0.req_ready !== 1'b1 || b0.rsp_valid !== 1'b0 || b0.dp_a !== 16'h3C00) begin
            errors++;
            $display("FAIL bp_release req_ready=%b rsp_valid=%b dp_a=%h want 1 0 3c00",
                     b0.req_ready, b0.rsp_valid, b0.dp_a);
        end
    endtask

    task automatic test_sticky();
        b0.sticky_clr = 1'b1;
        @(negedge clk);
        b0.sticky_clr = 1'b0;
        checks++;
        if (b0.sticky_flags !== 6'b0) begin
            errors++;
            $display("FAIL sticky_clr0 got=%b want=000000", b0.sticky_flags);
        end
        drive_req(16'h7C00, 16'h3C00, MUL_RN);
        repeat (3) @(negedge clk);
        checks++;
        if (b0.sticky_flags !== 6'b010000) begin
            errors++;
            $display("FAIL sticky_inf got=%b want=010000", b0.sticky_flags);
        end
        drive_req(16'h7E00, 16'h3C00, MUL_RN);
        repeat (3) @(negedge clk);
        checks++;
        if (b0.sticky_flags !== 6'b010010) begin
            errors++;
            $display("FAIL sticky_acc got=%b want=010010", b0.sticky_flags);
        end
        b0.sticky_clr = 1'b1;
        @(negedge clk);
        b0.sticky_clr = 1'b0;
        checks++;
        if (b0.sticky_flags !== 6'b0) begin
            errors++;
            $display("FAIL sticky_clr got=%b want=000000", b0.sticky_flags);
        end
        drive_req(16'h7C00, 16'h3C00, MUL_RN);
        repeat (3) @(negedge clk);
        drive_req(16'h3C00, 16'h4000, MUL_RN);
        @(negedge clk);
        b0.sticky_clr = 1'b1;
        @(negedge clk);
        b0.sticky_clr = 1'b0;
        checks++;
        if (b0.sticky_flags !== 6'b000100) begin
            errors++;
            $display("FAIL sticky_clr_cap got=%b want=000100", b0.sticky_flags);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        logic [21:0] exp;
        drive_req(16'h3C00, 16'h4000, MUL_RN);
        reset = 1'b1;
        #1;
        checks++;
        if ({b0.req_ready, b0.busy, b0.rsp_valid, b0.dp_ops_ready} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_ctl got=%b want=0000",
                     {b0.req_ready, b0.busy, b0.rsp_valid, b0.dp_ops_ready});
        end
        checks++;
        if ({b0.dp_a, b0.dp_b, b0.dp_op, b0.rsp_res, b0.rsp_flags,
             b0.sticky_flags} !== '0) begin
            errors++;
            $display("FAIL rst_mid_regs dp_a=%h sticky=%b rsp_res=%h want 0",
                     b0.dp_a, b0.sticky_flags, b0.rsp_res);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b0.rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || b0.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_abandon rsp_seen=%b req_ready=%b want 0 1",
                     seen, b0.req_ready);
        end
        sb.push_back({16'h4000, 6'b000100});
        drive_req(16'h3C00, 16'h4000, MUL_RN);
        repeat (2) @(negedge clk);
        exp = sb.pop_front();
        checks++;
        if (b0.rsp_valid !== 1'b1 || b0.rsp_res !== exp[21:6] ||
            b0.rsp_flags !== exp[5:0]) begin
            errors++;
            $display("FAIL rst_mid_next valid=%b res=%h flags=%b want 1 %h %b",
                     b0.rsp_valid, b0.rsp_res, b0.rsp_flags, exp[21:6], exp[5:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a_tab[4];
        logic [15:0] b_tab[4];
        logic [2:0]  o_tab[4];
        logic [21:0] exp;
        int idx, pulses, nrsp, last, cyc;
        logic adv;
        a_tab = '{16'h1111, 16'h2222, 16'h3C00, 16'h0001};
        b_tab = '{16'h2222, 16'h1111, 16'h5000, 16'h0002};
        o_tab = '{ADD_RN, SUB_SR, MUL_RN, MUL_SR};
        idx = 0;
        pulses = 0;
        nrsp = 0;
        last = 0;
        b0.req_a = a_tab[0];
        b0.req_b = b_tab[0];
        b0.req_op = o_tab[0];
        b0.req_valid = 1'b1;
        for (cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
            adv = 1'b0;
            if (b0.dp_ops_ready === 1'b1) pulses++;
            if (b0.rsp_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra rsp=%h want none", b0.rsp_res);
                end else begin
                    exp = sb.pop_front();
                    if (b0.rsp_res !== exp[21:6] || b0.rsp_flags !== exp[5:0]) begin
                        errors++;
                        $display("FAIL b2b_rsp[%0d] got=%h/%b want=%h/%b", nrsp,
                                 b0.rsp_res, b0.rsp_flags, exp[21:6], exp[5:0]);
                    end
                end
                if (nrsp > 0) begin
                    checks++;
                    if (cyc - last != 4) begin
                        errors++;
                        $display("FAIL b2b_space[%0d] got=%0d want=4", nrsp, cyc - last);
                    end
                end
                last = cyc;
                nrsp++;
            end
            if (b0.req_valid && b0.req_ready === 1'b1) begin
                sb.push_back(dp_fn(a_tab[idx], b_tab[idx], o_tab[idx]));
                idx++;
                adv = 1'b1;
            end
            @(negedge clk);
            if (adv) begin
                if (idx < 4) begin
                    b0.req_a = a_tab[idx];
                    b0.req_b = b_tab[idx];
                    b0.req_op = o_tab[idx];
                end else begin
                    b0.req_valid = 1'b0;
                end
            end
        end
        b0.req_valid = 1'b0;
        repeat (3) begin
            if (b0.dp_ops_ready === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (nrsp !== 4) begin
            errors++;
            $display("FAIL b2b_count got=%0d want=4", nrsp);
        end
        checks++;
        if (pulses !== 4) begin
            errors++;
            $display("FAIL b2b_pulses got=%0d want=4", pulses);
        end
        sb.delete();
    endtask

    task automatic test_min_latency();
        logic [21:0] exp;
        sb.push_back({16'h4000, 6'b000100});
        b1.req_a = 16'h3C00;
        b1.req_b = 16'h4000;
        b1.req_op = MUL_RN;
        b1.req_valid = 1'b1;
        @(negedge clk);
        b1.req_valid = 1'b0;
        checks++;
        if (b1.dp_ops_ready !== 1'b1 || b1.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat1_c1 ops_ready=%b rsp_valid=%b want 1 0",
                     b1.dp_ops_ready, b1.rsp_valid);
        end
        @(negedge clk);
        exp = sb.pop_front();
        checks++;
        if (b1.rsp_valid !== 1'b1 || b1.rsp_res !== exp[21:6] ||
            b1.rsp_flags !== exp[5:0]) begin
            errors++;
            $display("FAIL lat1_c2 valid=%b res=%h flags=%b want 1 %h %b",
                     b1.rsp_valid, b1.rsp_res, b1.rsp_flags, exp[21:6], exp[5:0]);
        end
        @(negedge clk);
        checks++;
        if (b1.req_ready !== 1'b1 || b1.dp_ops_ready !== 1'b0) begin
            errors++;
            $display("FAIL lat1_c3 req_ready=%b ops_ready=%b want 1 0",
                     b1.req_ready, b1.dp_ops_ready);
        end
    endtask

    initial begin
        reset = 1'b1;
        b0.req_valid = 1'b0;
        b0.req_a = '0;
        b0.req_b = '0;
        b0.req_op = '0;
        b0.rsp_ready = 1'b1;
        b0.sticky_clr = 1'b0;
        b1.req_valid = 1'b0;
        b1.req_a = '0;
        b1.req_b = '0;
        b1.req_op = '0;
        b1.rsp_ready = 1'b1;
        b1.sticky_clr = 1'b0;
        test_reset();
        test_basic_mul();
        test_backpressure();
        test_sticky();
        test_reset_mid_op();
        test_back_to_back();
        test_min_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
